// File: rtl/bilinear_mac_pipe.sv
// Pipelined 4-tap bilinear weighted sum for CH channels: multiply, pair-add, total/round/shift/saturate.
// One shared weight set per beat; valid/ready with a global advance and a saturation event counter.
module bilinear_mac_pipe #(
  parameter int DATA_W = 8,
  parameter int WGT_W  = 16,
  parameter int FRAC_W = 14,
  parameter int CH     = 1,
  parameter int OUT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4*WGT_W-1:0]       in_wgt,
  input  logic [4*CH*DATA_W-1:0]   in_data,
  input  logic                     in_rnd,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH*OUT_W-1:0]      out_data,
  output logic                     out_sat,
  output logic                     out_last,
  input  logic                     sat_clr,
  output logic [15:0]              sat_cnt
);

  localparam int PW = WGT_W + DATA_W;
  localparam int SW = PW + 1;
  // One spare bit above the 4-term sum so the rounding constant can never wrap.
  localparam int TW = PW + 3;
  localparam logic [TW-1:0] RND_K   = TW'(1) << (FRAC_W - 1);
  localparam logic [TW-1:0] SAT_MAX = TW'((64'd1 << OUT_W) - 64'd1);

  logic adv;
  logic v1, v2;
  logic rnd1, rnd2, last1, last2;
  logic [PW-1:0] prod_n [4*CH];
  logic [PW-1:0] prod   [4*CH];
  logic [SW-1:0] sum_a  [CH];
  logic [SW-1:0] sum_b  [CH];
  logic [TW-1:0] tot    [CH];
  logic [TW-1:0] shf    [CH];
  logic [CH*OUT_W-1:0] data_n;
  logic sat_n;
  logic sat_inc;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;
  assign sat_inc  = out_valid & out_ready & out_sat;

  // Stage-1 products: every tap of every channel against its tap weight.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < CH; c++) begin
        prod_n[k*CH+c] = PW'(in_wgt[k*WGT_W +: WGT_W]) * PW'(in_data[(k*CH+c)*DATA_W +: DATA_W]);
      end
    end
  end

  // Stage-3 combine: total, optional half-LSB rounding, fraction drop, clamp.
  always_comb begin
    data_n = {(CH*OUT_W){1'b0}};
    sat_n  = 1'b0;
    for (int c = 0; c < CH; c++) begin
      tot[c] = TW'(sum_a[c]) + TW'(sum_b[c]) + (rnd2 ? RND_K : {TW{1'b0}});
      shf[c] = tot[c] >> FRAC_W;
      if (shf[c] > SAT_MAX) begin
        data_n[c*OUT_W +: OUT_W] = {OUT_W{1'b1}};
        sat_n = 1'b1;
      end else begin
        data_n[c*OUT_W +: OUT_W] = shf[c][OUT_W-1:0];
      end
    end
  end

  // Datapath registers; no reset needed since validity is tracked separately.
  always_ff @(posedge clk) begin
    if (adv) begin
      prod  <= prod_n;
      rnd1  <= in_rnd;
      last1 <= in_last;
      for (int c = 0; c < CH; c++) begin
        sum_a[c] <= SW'(prod[c])      + SW'(prod[CH+c]);
        sum_b[c] <= SW'(prod[2*CH+c]) + SW'(prod[3*CH+c]);
      end
      rnd2  <= rnd1;
      last2 <= last1;
    end
  end

  // Stage valids and registered outputs; everything freezes while the output stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= {(CH*OUT_W){1'b0}};
      out_sat   <= 1'b0;
      out_last  <= 1'b0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      out_data  <= data_n;
      out_sat   <= sat_n & v2;
      out_last  <= last2 & v2;
    end
  end

  // Saturation event counter; clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt <= 16'd0;
    end else if (sat_clr) begin
      sat_cnt <= 16'd0;
    end else if (sat_inc && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_bilinear_mac_pipe.sv
// Randomised and directed bench for bilinear_mac_pipe (CH=3) against an arithmetic reference
// model with an in-order scoreboard, stall-hold checks and a saturation-count model.
module tb_bilinear_mac_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_rnd, in_last;
  logic [63:0]  in_wgt;
  logic [95:0]  in_data;
  logic         out_valid, out_ready, out_sat, out_last;
  logic [23:0]  out_data;
  logic         sat_clr;
  logic [15:0]  sat_cnt;

  always #5 clk = ~clk;

  bilinear_mac_pipe #(.DATA_W(8), .WGT_W(16), .FRAC_W(14), .CH(3), .OUT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_wgt(in_wgt),
    .in_data(in_data), .in_rnd(in_rnd), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat), .out_last(out_last),
    .sat_clr(sat_clr), .sat_cnt(sat_cnt)
  );

  typedef struct {
    logic [23:0] data;
    logic        sat;
    logic        last;
    int          acc;
  } beat_t;

  beat_t       sb[$];
  logic [23:0] outs[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          m_cnt = 0;
  logic        in_acc = 1'b0;
  logic        chk_lat = 1'b1;
  logic        held = 1'b0;
  logic [23:0] h_data;
  logic        h_sat, h_last;
  logic [23:0] last_out;
  logic        last_sat;
  int          sent;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: per channel, full-precision weighted sum, optional +0.5, drop fraction, clamp to 255.
  function automatic void ref_model(input logic [63:0] w, input logic [95:0] d, input logic rnd,
                                    output logic [23:0] o, output logic s);
    longint acc;
    o = 24'd0;
    s = 1'b0;
    for (int c = 0; c < 3; c++) begin
      acc = 0;
      for (int k = 0; k < 4; k++)
        acc += longint'(w[k*16 +: 16]) * longint'(d[(k*3+c)*8 +: 8]);
      if (rnd) acc += 8192;
      acc = acc / 16384;
      if (acc > 255) begin
        o[c*8 +: 8] = 8'd255;
        s = 1'b1;
      end else begin
        o[c*8 +: 8] = acc[7:0];
      end
    end
  endfunction

  function automatic logic [95:0] taps(input logic [7:0] d0, input logic [7:0] d1,
                                       input logic [7:0] d2, input logic [7:0] d3);
    logic [95:0] r;
    logic [7:0]  t [4];
    t[0] = d0; t[1] = d1; t[2] = d2; t[3] = d3;
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 3; c++)
        r[(k*3+c)*8 +: 8] = t[k];
    return r;
  endfunction

  // One clock: inputs were set after the falling edge; sample, score, then cross the rising edge.
  task automatic tick();
    beat_t e;
    logic  popped;
    logic  out_acc;
    #1;
    popped = 1'b0;
    in_acc = 1'b0;
    chk_val("sat_cnt", {16'd0, sat_cnt}, m_cnt);
    if (held) begin
      chk_val("hold_valid", {31'd0, out_valid}, 32'd1);
      chk_val("hold_data", {8'd0, out_data}, {8'd0, h_data});
      chk_val("hold_sat", {31'd0, out_sat}, {31'd0, h_sat});
      chk_val("hold_last", {31'd0, out_last}, {31'd0, h_last});
    end
    out_acc = out_valid & out_ready;
    if (out_acc) begin
      if (sb.size() == 0) begin
        chk_val("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        popped = 1'b1;
        chk_val("out_data", {8'd0, out_data}, {8'd0, e.data});
        chk_val("out_sat", {31'd0, out_sat}, {31'd0, e.sat});
        chk_val("out_last", {31'd0, out_last}, {31'd0, e.last});
        if (chk_lat) chk_val("latency", cyc - e.acc, 32'd3);
        last_out = out_data;
        last_sat = out_sat;
        outs.push_back(out_data);
      end
    end
    if (sat_clr) m_cnt = 0;
    else if (popped && e.sat && m_cnt < 65535) m_cnt++;
    held = out_valid & !out_ready;
    h_data = out_data;
    h_sat  = out_sat;
    h_last = out_last;
    if (in_valid && in_ready) begin
      in_acc = 1'b1;
      ref_model(in_wgt, in_data, in_rnd, e.data, e.sat);
      e.last = in_last;
      e.acc  = cyc;
      sb.push_back(e);
    end
    if (rst) begin
      sb.delete();
      m_cnt = 0;
      held  = 1'b0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [63:0] w, input logic [95:0] d, input logic rnd, input logic last);
    in_wgt = w; in_data = d; in_rnd = rnd; in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (in_acc) break;
    end
    chk_val("in_accept", {31'd0, in_acc}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) tick();
    chk_val("drain", sb.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_wgt = 64'd0; in_data = 96'd0; in_rnd = 1'b0;
    in_last = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_val("rst_valid", {31'd0, out_valid}, 32'd0);
    chk_val("rst_data", {8'd0, out_data}, 32'd0);
    chk_val("rst_sat", {31'd0, out_sat}, 32'd0);
    chk_val("rst_last", {31'd0, out_last}, 32'd0);
    chk_val("rst_cnt", {16'd0, sat_cnt}, 32'd0);

    // Equal quarter weights: mean of 10,20,30,40.
    send({4{16'h1000}}, taps(8'd10, 8'd20, 8'd30, 8'd40), 1'b0, 1'b1);
    drain();
    chk_val("avg_data", {8'd0, last_out}, 32'h00191919);
    chk_val("avg_sat", {31'd0, last_sat}, 32'd0);

    // Half/half of 1 and 2 (=1.5): truncate then round, back-to-back.
    outs.delete();
    send({16'h0, 16'h0, 16'h2000, 16'h2000}, taps(8'd1, 8'd2, 8'd0, 8'd0), 1'b0, 1'b0);
    send({16'h0, 16'h0, 16'h2000, 16'h2000}, taps(8'd1, 8'd2, 8'd0, 8'd0), 1'b1, 1'b0);
    drain();
    chk_val("n_outs", outs.size(), 32'd2);
    if (outs.size() == 2) begin
      chk_val("trunc_data", {8'd0, outs[0]}, 32'h00010101);
      chk_val("round_data", {8'd0, outs[1]}, 32'h00020202);
    end

    // Over-unity weights saturate; then clear coinciding with a saturated acceptance.
    send({4{16'h4000}}, taps(8'd255, 8'd255, 8'd255, 8'd255), 1'b0, 1'b0);
    drain();
    chk_val("sat_data", {8'd0, last_out}, 32'h00FFFFFF);
    chk_val("sat_flag", {31'd0, last_sat}, 32'd1);
    chk_val("sat_cnt_one", {16'd0, sat_cnt}, 32'd1);
    send({4{16'h4000}}, taps(8'd255, 8'd255, 8'd255, 8'd255), 1'b0, 1'b0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      sat_clr = out_valid;
      tick();
    end
    sat_clr = 1'b0;
    chk_val("sat_clr_prio", {16'd0, sat_cnt}, 32'd0);

    // Random stream with random backpressure, including a 5-cycle stall.
    chk_lat = 1'b0;
    sent = 0;
    for (int i = 0; i < 600 && !(sent == 20 && sb.size() == 0); i++) begin
      out_ready = (i >= 6 && i <= 10) ? 1'b0 : 1'($urandom % 2);
      if (!in_valid && sent < 20 && ($urandom % 4) != 0) begin
        in_wgt   = {16'($urandom_range(0, 24576)), 16'($urandom_range(0, 24576)),
                    16'($urandom_range(0, 24576)), 16'($urandom_range(0, 24576))};
        in_data  = {$urandom, $urandom, $urandom};
        in_rnd   = 1'($urandom % 2);
        in_last  = 1'($urandom % 2);
        in_valid = 1'b1;
      end
      tick();
      if (in_acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    chk_val("stream_done", {31'd0, (sent == 20 && sb.size() == 0)}, 32'd1);
    out_ready = 1'b1;
    chk_lat = 1'b1;

    // Reset with beats in flight: nothing stale may emerge afterwards.
    send({4{16'h1000}}, taps(8'd1, 8'd2, 8'd3, 8'd4), 1'b0, 1'b0);
    send({4{16'h1000}}, taps(8'd5, 8'd6, 8'd7, 8'd8), 1'b0, 1'b1);
    send({4{16'h1000}}, taps(8'd9, 8'd9, 8'd9, 8'd9), 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_val("rst_flush", {31'd0, out_valid}, 32'd0);
    repeat (6) tick();
    send({16'h0800, 16'h1800, 16'h1000, 16'h1000}, taps(8'd40, 8'd80, 8'd120, 8'd200), 1'b1, 1'b1);
    drain();

    // Long saturating stream: the counter must stick at 0xFFFF.
    in_wgt = {4{16'h4000}}; in_data = taps(8'd255, 8'd255, 8'd255, 8'd255);
    in_rnd = 1'b0; in_last = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    in_valid = 1'b0;
    drain();
    chk_val("sat_stick", {16'd0, sat_cnt}, 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bilinear_mac_pipe.md
Name: bilinear_mac_pipe

Overview:
- Pipelined, parametrised successor to the Resizer's combinational 4-tap weighted-sum array.
- Computes SUM = (W00·D00 + W01·D01 + W10·D10 + W11·D11) >> FRAC_W for CH colour channels in parallel, using one shared weight set per beat.
- Adds a valid/ready handshake, optional rounding, saturation to OUT_W with a flag, end-of-line sideband, and a saturation event counter.
- Sits between the Resizer window fetch and the output line writer.

Parameters:
- DATA_W, 8, pixel channel width (unsigned).
- WGT_W, 16, weight width (unsigned fixed point).
- FRAC_W, 14, weight fraction bits; 1.0 = 2^FRAC_W; must satisfy 1 <= FRAC_W < WGT_W.
- CH, 1, number of channels processed per beat (for example 3 for RGB).
- OUT_W, 8, output channel width after saturation.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_wgt  in  4*WGT_W  tap k (0=00, 1=01, 2=10, 3=11) at [k*WGT_W +: WGT_W].
- in_data  in  4*CH*DATA_W  tap k, channel c at [(k*CH+c)*DATA_W +: DATA_W].
- in_rnd  in  1  round-half-up enable, travels with the beat.
- in_last  in  1  end-of-line marker, travels with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  CH*OUT_W  channel c at [c*OUT_W +: OUT_W].
- out_sat  out  1  at least one channel of this beat saturated.
- out_last  out  1  delayed in_last.
- sat_clr  in  1  clears sat_cnt.
- sat_cnt  out  16  count of accepted output beats with out_sat=1; sticks at 0xFFFF.

Behaviour:
- Reset (clk edge with rst=1): all stage valids=0; out_valid=0; out_data=0; out_sat=0; out_last=0; sat_cnt=0. A reset mid-stream discards all in-flight beats; no partial outputs appear.
- Pipeline: 3 register stages. Latency is exactly 3 cycles from an accepted input to out_valid when not stalled.
  - S1: 4·CH products, each WGT_W+DATA_W bits. Registers in_rnd and in_last.
  - S2: pairwise sums (P00+P01), (P10+P11), each +1 bit.
  - S3: total (+2 bits); add 2^(FRAC_W-1) if rnd; shift right by FRAC_W; saturate to 2^OUT_W-1.
- All arithmetic is unsigned and full width, with no intermediate truncation.
- Saturation: per channel, if the shifted value exceeds 2^OUT_W-1, the output is 2^OUT_W-1. out_sat is the OR over channels.
- Handshake and stall:
  - adv = !out_valid | out_ready; in_ready = adv.
  - Every stage advances only when adv=1.
  - While out_valid=1 and out_ready=0, out_data, out_sat and out_last hold stable.
  - Beats are never dropped or duplicated.
  - Bubbles are not compressed.
- Transfer rule: an input is accepted when in_valid & in_ready; an output is accepted when out_valid & out_ready.
- Throughput: 1 beat per cycle when out_ready is held at 1.
- sat_cnt:
  - Increments on each accepted output beat with out_sat=1, saturating at 0xFFFF.
  - sat_clr has priority: when it coincides with an increment, the result is 0.
- Weights are not checked for a sum of 1.0. Over-unity weight sets are handled by saturation only.

Test Plan:
- Defaults; W=0x1000 ×4; D=10,20,30,40; rnd=0 → out_data=25 three cycles later, out_sat=0.
- W=0x2000,0x2000,0,0; D00=1, D01=2: rnd=0 → 1; rnd=1 → 2. Send back-to-back in consecutive cycles; outputs appear in order on consecutive cycles.
- W=0x4000 ×4, D=255 ×4 → out_data=255, out_sat=1, sat_cnt 0→1. Assert sat_clr in the same cycle as a second saturated acceptance → sat_cnt=0.
- CH=3; stream 20 beats with random data; out_ready toggles 0/1 pseudo-randomly (including 5 consecutive low cycles).
  - Outputs must match the scoreboard exactly and in order.
  - in_last must pass through on its beat.
  - Outputs must stay stable during stalls.
- Pulse rst with 3 beats in flight → out_valid=0 the next cycle; no stale beats emerge afterwards; the first new beat appears 3 cycles after its acceptance.
- Force sat_cnt to 0xFFFF (or run a long saturating stream) → it remains 0xFFFF on further saturated beats.
